// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared encodings and constants for the EX-stage divider.
package ex_div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam int DoubleRegBus = 64;

endpackage

// File: rtl/ex_div_if.sv
// rtl/ex_div_if.sv - EX <-> divider request/result bundle; div_zero_o exists only with DIV_ZERO_FLAG_EN.
interface ex_div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
`ifdef DIV_ZERO_FLAG_EN
    logic                  div_zero_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, div_zero_o
    );
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, div_zero_o
    );
`else
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
`endif
endinterface

// File: rtl/ex_div_sign_fix.sv
// rtl/ex_div_sign_fix.sv - conditional two's-complement negate (div_sign_fix).
module ex_div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = neg_i ? (~data_i + WIDTH'(1)) : data_i;

endmodule

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle radix-2 restoring divider for DIV/DIVU.
// Optional divide-by-zero flag output enabled by DIV_ZERO_FLAG_EN.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    ex_div_if.slave   div_if
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   dvd_q;
    logic [DATA_W-1:0]   dvs_q;
    logic                signed_q;
    logic                sign1_q;
    logic                sign2_q;
    logic [2*DATA_W-1:0] result_q;
    logic                ready_q;
`ifdef DIV_ZERO_FLAG_EN
    logic                div_zero_q;
`endif

    logic [DATA_W-1:0]   op1_abs;
    logic [DATA_W-1:0]   op2_abs;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W:0]     trial;

    ex_div_sign_fix #(.WIDTH(DATA_W)) u_abs1 (
        .data_i (div_if.opdata1_i),
        .neg_i  (div_if.signed_div_i & div_if.opdata1_i[DATA_W-1]),
        .data_o (op1_abs)
    );

    ex_div_sign_fix #(.WIDTH(DATA_W)) u_abs2 (
        .data_i (div_if.opdata2_i),
        .neg_i  (div_if.signed_div_i & div_if.opdata2_i[DATA_W-1]),
        .data_o (op2_abs)
    );

    ex_div_sign_fix #(.WIDTH(DATA_W)) u_fix_quo (
        .data_i (dvd_q),
        .neg_i  (signed_q & (sign1_q ^ sign2_q)),
        .data_o (quo_fix)
    );

    ex_div_sign_fix #(.WIDTH(DATA_W)) u_fix_rem (
        .data_i (rem_q),
        .neg_i  (signed_q & sign1_q),
        .data_o (rem_fix)
    );

    // The dividend register doubles as the quotient: each step shifts a
    // dividend bit out of the top and a quotient bit in at the bottom.
    assign trial = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dvs_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            signed_q   <= 1'b0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                DivFree: begin
                    if (div_if.start_i == DivStart && !div_if.annul_i) begin
                        if (div_if.opdata2_i == '0) begin
                            state_q <= DivByZero;
                        end else begin
                            state_q  <= DivOn;
                            dvd_q    <= op1_abs;
                            dvs_q    <= op2_abs;
                            signed_q <= div_if.signed_div_i;
                            sign1_q  <= div_if.opdata1_i[DATA_W-1];
                            sign2_q  <= div_if.opdata2_i[DATA_W-1];
                            cnt_q    <= '0;
                            rem_q    <= '0;
                        end
                    end
                end
                DivByZero: begin
                    state_q    <= DivEnd;
                    result_q   <= '0;
                    ready_q    <= DivResultReady;
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_q <= 1'b1;
`endif
                end
                DivOn: begin
                    if (div_if.annul_i) begin
                        state_q  <= DivFree;
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
                    end else if (cnt_q != CNT_W'(DATA_W)) begin
                        if (trial[DATA_W]) begin
                            rem_q <= {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]};
                        end else begin
                            rem_q <= trial[DATA_W-1:0];
                        end
                        dvd_q <= {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        state_q  <= DivEnd;
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= DivResultReady;
                    end
                end
                DivEnd: begin
                    if (div_if.start_i == DivStop || div_if.annul_i) begin
                        state_q    <= DivFree;
                        result_q   <= '0;
                        ready_q    <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= DivFree;
            endcase
        end
    end

    assign div_if.result_o   = result_q;
    assign div_if.ready_o    = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    assign div_if.div_zero_o = div_zero_q;
`endif

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - scoreboard bench for ex_div (DIV_ZERO_FLAG_EN optional).
module tb_ex_div;
    import ex_div_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic        zf;
        int          lat;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_div_if #(.DATA_W(32)) bus ();

    ex_div #(.DATA_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (bus.slave)
    );

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   edges = 0;
    logic prev_ready = 1'b0;

    // Edges seen since start_i was first sampled high.
    always @(posedge clk) begin
        if (bus.start_i) edges = edges + 1;
        else             edges = 0;
    end

    always @(negedge clk) begin
        if (bus.ready_o === 1'b1 && prev_ready !== 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_ready: ready_o=1 result=%h, no operation pending", bus.result_o);
            end else begin
                e = sb.pop_front();
                n_vec++;
                if (bus.result_o !== e.res) begin
                    n_err++;
                    $display("FAIL %s result: got %h expected %h", e.name, bus.result_o, e.res);
                end
                n_vec++;
                if (edges - 1 != e.lat) begin
                    n_err++;
                    $display("FAIL %s latency: got %0d expected %0d", e.name, edges - 1, e.lat);
                end
`ifdef DIV_ZERO_FLAG_EN
                n_vec++;
                if (bus.div_zero_o !== e.zf) begin
                    n_err++;
                    $display("FAIL %s div_zero: got %b expected %b", e.name, bus.div_zero_o, e.zf);
                end
`endif
            end
        end
        if (bus.ready_o === 1'b0 && prev_ready === 1'b1) begin
            n_vec++;
            if (bus.result_o !== 64'h0) begin
                n_err++;
                $display("FAIL result_clear: got %h expected 0", bus.result_o);
            end
        end
        prev_ready = bus.ready_o;
    end

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] r, input logic zf, input int lat,
                         input string nm, output bit done);
        exp_t x;
        @(negedge clk);
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = DivStart;
        x.res = r; x.zf = zf; x.lat = lat; x.name = nm;
        sb.push_back(x);
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) done = 1'b1;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: ready_o not seen within 60 cycles, expected after %0d", nm, lat);
            void'(sb.pop_back());
        end
    endtask

    task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] r, input logic zf, input int lat, input string nm);
        bit done;
        issue(s, a, b, r, zf, lat, nm, done);
        if (done) begin
            @(negedge clk);
            n_vec++;
            if (bus.ready_o !== 1'b1 || bus.result_o !== r) begin
                n_err++;
                $display("FAIL %s hold: ready=%b result=%h expected ready=1 result=%h",
                         nm, bus.ready_o, bus.result_o, r);
            end
        end
        bus.start_i = DivStop;
        @(negedge clk);
        n_vec++;
        if (bus.ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s drop: ready_o=%b expected 0", nm, bus.ready_o);
        end
    endtask

    initial begin
        bit seen;
        bit done;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = DivStop;
        bus.annul_i      = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            n_err++;
            $display("FAIL reset: ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
        end
        rst = 1'b0;

        run(1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 1'b0, 33, "udiv_100_7");
        run(1'b1, 32'hFFFFFFF9,   32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33, "sdiv_m7_2");
        run(1'b1, 32'h00000007,   32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 33, "sdiv_7_m2");
        run(1'b1, 32'hFFFFFF9C,   32'd7,        64'hFFFFFFFE_FFFFFFF2, 1'b0, 33, "sdiv_m100_7");
        run(1'b0, 32'd5,          32'd0,        64'h0,                 1'b1, 1,  "div_zero");
        run(1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 1'b0, 33, "udiv_max_1");
        run(1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 33, "sdiv_wrap");
        run(1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 1'b0, 33, "udiv_small_q");
        run(1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'h00000000_00000001, 1'b0, 33, "sdiv_m1_m1");
        run(1'b0, 32'd0,          32'd5,        64'h0,                 1'b0, 33, "udiv_0_5");

        // Annul at iteration 10: no result may appear.
        @(negedge clk);
        bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
        bus.start_i = DivStart;
        repeat (11) @(negedge clk);
        bus.annul_i = 1'b1; bus.start_i = DivStop;
        @(negedge clk);
        bus.annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready_o !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL annul_quiet: ready_o went high within 40 cycles, expected 0");
        end
        run(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33, "after_annul");

        // Asynchronous reset while a result is being presented.
        issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33, "pre_reset", done);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            n_err++;
            $display("FAIL async_reset_end: ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
        end
        bus.start_i = DivStop;
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-iteration, then a fresh divide.
        @(negedge clk);
        bus.signed_div_i = 1'b1; bus.opdata1_i = 32'hFFFFFFF9; bus.opdata2_i = 32'd2;
        bus.start_i = DivStart;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            n_err++;
            $display("FAIL async_reset_mid: ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
        end
        bus.start_i = DivStop;
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33, "after_reset");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle radix-2 restoring divider used by the EX stage for DIV/DIVU.
- EX drives it from the operands and ALU op registered out of the ID/EX pipeline register.
- EX holds start_i while the divide runs and raises its stall request until ready_o is seen.
- The 64-bit result goes to HI/LO through the EX/MEM path.

Parameters:
- DATA_W, 32: operand width. The result is 2*DATA_W.
- CNT_W, $clog2(DATA_W)+1: iteration counter width. Derived; do not override.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Asynchronous reset, active-high.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled with start_i.
- opdata1_i  in  DATA_W  Dividend. Sampled with start_i.
- opdata2_i  in  DATA_W  Divisor. Sampled with start_i.
- start_i  in  1  Request. Held high by EX until ready_o is seen, then dropped.
- annul_i  in  1  Abort the divide in flight (pipeline flush or exception).
- result_o  out  2*DATA_W  {remainder, quotient}: upper half to HI, lower half to LO.
- ready_o  out  1  Result valid. Held while start_i stays high.
- div_zero_o  out  1  Present only with DIV_ZERO_FLAG_EN.

Behaviour:
- Reset: one clock and one asynchronous active-high reset; rst forces state FREE, ready_o=0, result_o=0, counter=0 and the working registers to 0, regardless of clk. Reset mid-divide discards the operation.
- FREE:
  - start_i=1, annul_i=0, divisor==0 -> ZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. On this edge:
    - latch |dividend| and |divisor| (two's-complement negate when signed_div_i=1 and MSB=1);
    - latch signed_div_i and both operand sign bits;
    - cnt=0; partial-remainder register cleared.
  - Otherwise stay in FREE.
- ZERO: next edge -> END with result_o=0 and ready_o=1.
- ON, annul_i=1: next edge -> FREE; ready_o stays 0; result_o=0. annul_i has priority over iteration.
- ON, annul_i=0 and cnt<DATA_W, one iteration per edge:
  - trial = {rem[DATA_W-1:0], dividend MSB} - {1'b0, divisor}, computed DATA_W+1 bits wide;
  - trial MSB=1 (negative): shift left, quotient bit = 0;
  - trial MSB=0: rem = trial[DATA_W-1:0], quotient bit = 1;
  - cnt++.
- ON, cnt==DATA_W: next edge -> END with sign fix-up:
  - quotient negated if signed and operand signs differ;
  - remainder negated if signed and dividend was negative;
  - ready_o=1.
- END:
  - result_o and ready_o held stable.
  - start_i=0 or annul_i=1: next edge -> FREE, ready_o=0, result_o=0.
- Latency, counted from the edge that samples start_i:
  - ready_o is high after DATA_W+1 further edges (33 at DATA_W=32);
  - divide-by-zero: after 1 further edge.
- Wrap case: signed 0x80000000 / -1 gives quotient 0x80000000, remainder 0. No trap.
- start_i arriving while in ON or ZERO is ignored; no re-sampling occurs.
- ready_o is a registered output; it depends on no combinational input.

Optional Feature:
- DIV_ZERO_FLAG_EN defined:
  - port div_zero_o exists;
  - set to 1 on entry to END from ZERO, cleared on leaving END and by reset.
  - EX may forward it into the exception-type bus.
- Not defined: the port and its logic are absent. Divide-by-zero yields result 0 and ready only; the architectural result is UNPREDICTABLE, so 0 is acceptable.

Decomposition:
- Shared defines header gets:
  - state encodings DivFree, DivByZero, DivOn, DivEnd (2 bits);
  - DivStart/DivStop and DivResultReady/DivResultNotReady;
  - DoubleRegBus.
- One natural sub-module: div_sign_fix, a combinational conditional two's-complement negate of width DATA_W, instantiated for operand absolute value and for result fix-up.
- The FSM and iteration datapath stay in ex_div.

Test Plan:
- Unsigned 100/7, start held: after 33 edges, ready_o=1 and result_o=0x00000002_0000000E. Drop start: next edge ready_o=0, result_o=0.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002): result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2: result_o=0x00000001_FFFFFFFD.
- Divisor 0 (5/0): ready_o=1 one edge after start, result_o=0. With DIV_ZERO_FLAG_EN, div_zero_o=1 in the same cycle.
- Boundary: unsigned 0xFFFFFFFF/1 gives 0x00000000_FFFFFFFF. Signed 0x80000000/0xFFFFFFFF gives 0x00000000_80000000.
- annul_i pulsed at iteration 10: next edge state FREE, ready_o stays 0 for 40 cycles. A new start then completes correctly (100/7).
- rst asserted asynchronously mid-iteration, between clock edges: ready_o and result_o go to 0 immediately. After release, FREE accepts a fresh start.
